// File: rtl/fifo_rd_drain.sv
// Read-side drain engine for the async FIFO: issues credit-limited reads in the
// r_clk domain and presents the returned words on a valid/ready stream.
module fifo_rd_drain #(
    parameter int size  = 8,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             emptyN,
    input  logic [size-1:0]  dataout,
    output logic             r_en,
    output logic [size-1:0]  m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t            state_q;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic [size-1:0]   head_q, head_d;
    logic [size-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop_s;
    logic [2:0]        credit_s;

    assign pop_s    = (occ_q != 2'd0) & m_ready;
    // Slots that will be claimed after this edge; a new read needs one left free.
    assign credit_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign r_en     = !clr & (state_q == RUN) & emptyN & (credit_s < 3'd2);

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = head_q;
    assign rd_count = cnt_q;
    assign busy     = (state_q != IDLE) | (occ_q != 2'd0) | inflight_q;

    // Next-state for the skid buffer, in-flight flag and accepted-word counter.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = r_en;
        occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, pop_s};
        case ({inflight_q, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = dataout;
                end else begin
                    tail_d = dataout;
                end
            end
            2'b01: begin
                head_d = tail_q;
            end
            2'b11: begin
                // Head leaves while a new word lands: it goes wherever the new tail is.
                if (occ_q == 2'd1) begin
                    head_d = dataout;
                end else begin
                    head_d = tail_q;
                    tail_d = dataout;
                end
            end
            default: begin
                head_d = head_q;
            end
        endcase
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge r_clk) begin
        if (clr) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= {size{1'b0}};
            tail_q     <= {size{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
        end
    end

    // Control FSM: STOP lets the in-flight word and buffered words drain out.
    always_ff @(posedge r_clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) state_q <= RUN;
                    else        state_q <= IDLE;
                end
                RUN: begin
                    if (!enable) state_q <= STOP;
                    else         state_q <= RUN;
                end
                STOP: begin
                    if (enable)                                state_q <= RUN;
                    else if (!inflight_q && occ_q == 2'd0)     state_q <= IDLE;
                    else                                       state_q <= STOP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
